// File: rtl/asteroid_field.sv
// Four wrapping asteroids moved once per frame during vertical blank, plus a
// registered per-pixel renderer with lowest-index priority on overlap.
module asteroid_field #(
  parameter int          SIZE     = 16,
  parameter logic [11:0] FG_COLOR = 12'hAAA,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        obj_on,
  output logic [1:0]  obj_id,
  output logic [15:0] frame_count,
  output logic        dbg_state,
  output logic [1:0]  dbg_idx
);

  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  UPDATE = 1'b1;
  localparam logic [11:0] SZ     = 12'(SIZE);

  localparam logic [10:0] RST_X  [4] = '{11'd100, 11'd300, 11'd500, 11'd20};
  localparam logic [10:0] RST_Y  [4] = '{11'd50,  11'd200, 11'd400, 11'd300};
  localparam logic [3:0]  RST_VX [4] = '{4'h1, 4'hE, 4'h3, 4'hF};
  localparam logic [3:0]  RST_VY [4] = '{4'h1, 4'h1, 4'hF, 4'hE};

  logic [0:0]  state;
  logic [1:0]  idx;
  logic [10:0] prev_y;
  logic        frame_tick;
  logic [10:0] ax [4];
  logic [10:0] ay [4];
  logic [3:0]  vx [4];
  logic [3:0]  vy [4];
  logic        hit;
  logic [1:0]  hit_id;

  assign dbg_state  = state;
  assign dbg_idx    = idx;
  assign frame_tick = (pixel_y == 11'd480) && (prev_y != 11'd480);

  // p + v in 12-bit two's complement, folded back into [0, lim).
  function automatic logic [10:0] wrap_axis(input logic [10:0] p,
                                            input logic [3:0]  v,
                                            input logic [11:0] lim);
    logic [11:0] s;
    logic [11:0] r;
    s = {1'b0, p} + {{8{v[3]}}, v};
    if (s[11])         r = s + lim;
    else if (s >= lim) r = s - lim;
    else               r = s;
    return r[10:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_y      <= '0;
      frame_count <= '0;
    end else begin
      prev_y <= pixel_y;
      if (frame_tick) frame_count <= frame_count + 16'd1;
    end
  end

  // A tick arriving mid-update is dropped, never queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick && !pause) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        default: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ax[i] <= RST_X[i];
        ay[i] <= RST_Y[i];
        vx[i] <= RST_VX[i];
        vy[i] <= RST_VY[i];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == UPDATE && idx == 2'(i)) begin
          ax[i] <= wrap_axis(ax[i], vx[i], 12'd640);
          ay[i] <= wrap_axis(ay[i], vy[i], 12'd480);
        end
      end
    end
  end

  // Scan from the highest index down so the lowest covering index wins.
  always_comb begin
    hit    = 1'b0;
    hit_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (({1'b0, pixel_x} >= {1'b0, ax[i]}) && ({1'b0, pixel_x} < {1'b0, ax[i]} + SZ) &&
          ({1'b0, pixel_y} >= {1'b0, ay[i]}) && ({1'b0, pixel_y} < {1'b0, ay[i]} + SZ)) begin
        hit    = 1'b1;
        hit_id = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb    <= '0;
      obj_on <= 1'b0;
      obj_id <= '0;
    end else if (!video_on) begin
      rgb    <= '0;
      obj_on <= 1'b0;
      obj_id <= '0;
    end else if (hit) begin
      rgb    <= FG_COLOR;
      obj_on <= 1'b1;
      obj_id <= hit_id;
    end else begin
      rgb    <= BG_COLOR;
      obj_on <= 1'b0;
      obj_id <= '0;
    end
  end

endmodule
